// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler.
// Contents: opcode constants, FSM state encoding, requester-id width
// and an opcode legality helper used by the scheduler and its ALU.
package alu_sched_pkg;

  // Opcode encodings presented on req_op0/req_op1
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Width of the requester index carried on rsp_id
  localparam int ID_W = 1;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for the five defined opcodes; everything else is flagged as an error
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu32.sv
// Purpose: combinational ALU (add/sub/and/or/xor); illegal opcodes pass data1 through.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result when it needs it.
// Ports: ctrl = opcode, data1/data2 = operands, result = W-bit result.
module alu32
  import alu_sched_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   ctrl,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  output logic [W-1:0] result
);

  always_comb begin
    result = data1;
    case (ctrl)
      OP_ADD:  result = data1 + data2;
      OP_SUB:  result = data1 - data2;
      OP_AND:  result = data1 & data2;
      OP_OR:   result = data1 | data2;
      OP_XOR:  result = data1 ^ data2;
      default: result = data1;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Purpose: round-robin scheduler feeding one ALU from two requesters, one op in flight.
// Latency: accept at edge N, response registered at edge N+1 and seen valid at edge N+2.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports: clk/rst_n; req_valid/req_ready per requester; req_op*/req_a*/req_b* operands;
//        rsp_valid/rsp_ready handshake with rsp_id/rsp_data/rsp_carry/rsp_zero/rsp_err.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREQ = 2     // only 2 is supported (one-bit requester id)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [2:0]      req_op0,
  input  logic [2:0]      req_op1,
  input  logic [W-1:0]    req_a0,
  input  logic [W-1:0]    req_b0,
  input  logic [W-1:0]    req_a1,
  input  logic [W-1:0]    req_b1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_carry,
  output logic            rsp_zero,
  output logic            rsp_err
);

  state_t          r_state;
  logic [ID_W-1:0] r_prio;     // requester that wins when both ask
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [ID_W-1:0] r_id;

  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [W-1:0]    r_rsp_data;
  logic            r_rsp_carry;
  logic            r_rsp_zero;
  logic            r_rsp_err;

  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant_id;
  logic            w_accept;
  logic [NREQ-1:0] w_ready;
  logic [2:0]      w_sel_op;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [W-1:0]    w_alu_res;
  logic            w_add_carry;
  logic            w_sub_borrow;
  logic            w_carry;

  // Arbitration: a lone requester always wins; a tie goes to r_prio.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    if (req_valid[0] && req_valid[1]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_prio;
    end else if (req_valid[0]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (req_valid[1]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end
  end

  // rst_n gates acceptance so req_ready is low for the whole reset window,
  // while still allowing a grant on the first edge after release.
  assign w_accept = (r_state == ST_IDLE) && w_grant_vld && rst_n;

  always_comb begin
    w_ready             = '0;
    w_ready[w_grant_id] = w_accept;
  end

  assign req_ready = w_ready;

  assign w_sel_op = w_grant_id[0] ? req_op1 : req_op0;
  assign w_sel_a  = w_grant_id[0] ? req_a1  : req_a0;
  assign w_sel_b  = w_grant_id[0] ? req_b1  : req_b0;

  // ALU sees only the latched operands, never the live request ports
  alu32 #(.W(W)) u_alu32 (
    .ctrl   (r_op),
    .data1  (r_a),
    .data2  (r_b),
    .result (w_alu_res)
  );

  // Carry/borrow regenerated locally from the operand registers
  assign w_add_carry  = 1'(({1'b0, r_a} + {1'b0, r_b}) >> W);
  assign w_sub_borrow = (r_b > r_a);

  always_comb begin
    w_carry = 1'b0;
    if (r_op == OP_ADD) w_carry = w_add_carry;
    else if (r_op == OP_SUB) w_carry = w_sub_borrow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_grant_id;
            r_prio  <= ~w_grant_id;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_alu_res;
          r_rsp_carry <= w_carry;
          r_rsp_zero  <= (w_alu_res == '0);
          r_rsp_err   <= ~op_is_legal(r_op);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;

endmodule
